// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: streams one frame into a conv feature map and collects its outputs; define CONV_SEQ_PERF_EN to build the perf_cycles counter
module conv_layer_sequencer #(
  parameter int IMG_SIZE = 416,
  parameter int DATA_IN_WIDTH = 96,
  parameter int ADDR_WIDTH = 18,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [DATA_IN_WIDTH-1:0] mem_rd_data,
  output logic [DATA_IN_WIDTH-1:0] fm_data,
  output logic                     fm_valid,
  output logic                     fm_last,
  input  logic                     conv_valid,
  output logic                     out_wr_en,
  output logic [ADDR_WIDTH-1:0]    out_wr_addr,
  output logic [31:0]              perf_cycles
);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] N_OUT = ADDR_WIDTH'((IMG_SIZE - 2) * (IMG_SIZE - 2));
  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IW-1:0] TO_LAST = IW'(DRAIN_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] issue_cnt, out_count;
  logic [IW-1:0] idle_cnt;
  logic full, full_nxt, timeout, accept;
  always_comb begin
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    mem_rd_en = state == RUN && !hold;
    mem_rd_addr = issue_cnt;
    fm_data = mem_rd_data;
    full = out_count == N_OUT;
    out_wr_en = conv_valid && busy && !full;
    out_wr_addr = out_count;
    full_nxt = full || (out_wr_en && out_count == N_OUT - 1'b1);
    timeout = state == DRAIN && !full_nxt && !conv_valid && idle_cnt == TO_LAST;
    accept = state == IDLE && start;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = (mem_rd_en && issue_cnt == LAST_PIX) ? DRAIN : RUN;
      DRAIN:   state_nxt = full_nxt ? DONE : timeout ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      issue_cnt <= '0;
      out_count <= '0;
      idle_cnt <= '0;
      error <= 1'b0;
      fm_valid <= 1'b0;
      fm_last <= 1'b0;
    end else begin
      state <= state_nxt;
      fm_valid <= mem_rd_en;
      fm_last <= mem_rd_en && issue_cnt == LAST_PIX;
      if (accept) begin
        issue_cnt <= '0;
        out_count <= '0;
        idle_cnt <= '0;
        error <= 1'b0;
      end else begin
        if (mem_rd_en) issue_cnt <= issue_cnt + 1'b1;
        if (out_wr_en) out_count <= out_count + 1'b1;
        if (state == DRAIN) idle_cnt <= conv_valid ? '0 : idle_cnt + 1'b1;
        if (timeout) error <= 1'b1;
      end
    end
  end
`ifdef CONV_SEQ_PERF_EN
  // snapshot includes the final busy cycle
  logic [31:0] perf_cnt, perf_inc;
  always_comb perf_inc = &perf_cnt ? perf_cnt : perf_cnt + 1'b1;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_cnt <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept) perf_cnt <= '0;
      else if (busy) perf_cnt <= perf_inc;
      if ((state == DRAIN && full_nxt) || timeout) perf_cycles <= perf_inc;
    end
  end
`else
  always_comb perf_cycles = '0;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: randomized frames checked against a per-cycle rule model of the sequencer
module tb_conv_layer_sequencer;
  localparam int N = 4;
  localparam int NPIX = N * N;
  localparam int TGT = (N - 2) * (N - 2);
  localparam int TO = 8;
  localparam int AW = 8;
  localparam int DW = 96;
  localparam logic [15:0] CM_STD = 16'hCC00;
  logic Clk, Rst, start, hold, busy, done, error, mem_rd_en, fm_valid, fm_last, conv_valid, out_wr_en;
  logic [AW-1:0] mem_rd_addr, out_wr_addr;
  logic [DW-1:0] mem_rd_data, fm_data;
  logic [31:0] perf_cycles;
  logic [DW-1:0] mem [NPIX];
  int n_chk = 0, n_pass = 0;
  int m_ph = 0, m_iss = 0, m_outs = 0, m_idle = 0, m_perf = 0, m_perf_last = 0, m_fa = 0;
  bit m_err = 0, m_fv = 0;

  conv_layer_sequencer #(.IMG_SIZE(N), .DATA_IN_WIDTH(DW), .ADDR_WIDTH(AW), .DRAIN_TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .hold(hold), .busy(busy), .done(done), .error(error),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .fm_data(fm_data),
    .fm_valid(fm_valid), .fm_last(fm_last), .conv_valid(conv_valid), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .perf_cycles(perf_cycles));

  initial Clk = 0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[3:0]];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] perf_exp();
`ifdef CONV_SEQ_PERF_EN
    return m_perf_last;
`else
    return 0;
`endif
  endfunction

  // one clock cycle: drive inputs, check outputs at negedge, then advance the model
  task automatic step(input bit st, input bit hd, input bit cx, input bit rs, input logic [15:0] cm);
    bit cv, rd, wr, bz;
    @(posedge Clk);
    #1;
    cv = (m_fv && cm[m_fa]) || cx;
    start = st;
    hold = hd;
    conv_valid = cv;
    Rst = rs;
    @(negedge Clk);
    bz = m_ph == 1 || m_ph == 2;
    rd = m_ph == 1 && !hd;
    wr = cv && bz && m_outs < TGT;
    check("ctl", {busy, done, error, mem_rd_en, fm_valid, fm_last, out_wr_en},
          {bz, m_ph == 3, m_err, rd, m_fv, m_fv && m_fa == NPIX - 1, wr});
    if (rd) check("rd_addr", mem_rd_addr, m_iss);
    if (m_fv) check("fm_data", fm_data, mem[m_fa]);
    if (wr) check("wr_addr", out_wr_addr, m_outs);
    if (rs) begin
      m_ph = 0; m_iss = 0; m_outs = 0; m_idle = 0; m_perf = 0; m_perf_last = 0; m_err = 0; m_fv = 0;
    end else begin
      m_fv = rd;
      m_fa = m_iss;
      if (bz) m_perf++;
      if (wr) m_outs++;
      case (m_ph)
        0: if (st) begin
          m_ph = 1; m_iss = 0; m_outs = 0; m_idle = 0; m_err = 0; m_perf = 0;
        end
        1: if (rd) begin
          m_iss++;
          if (m_iss == NPIX) m_ph = 2;
        end
        2: if (m_outs == TGT) begin
          m_ph = 3;
          m_perf_last = m_perf;
        end else if (cv) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TO) begin
            m_err = 1; m_ph = 0; m_perf_last = m_perf;
          end
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic frame(input logic [63:0] hm, input logic [15:0] cm, input bit noise, input int rst_at);
    int c;
    bit hd, rs, st;
    step(1, 0, 0, 0, cm);
    c = 0;
    while (m_ph != 0) begin
      c++;
      if (c > 200) begin
        check("frame_bound", c, 200);
        break;
      end
      rs = rst_at >= 0 && m_ph == 1 && m_iss == rst_at;
      hd = (c < 64 && !rs) ? hm[c] : 1'b0;
      st = noise && (m_ph == 1 || m_ph == 2) && $urandom_range(0, 2) == 0;
      step(st, hd, 0, rs, cm);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 0, '0);
      if (i == 0) check("perf", perf_cycles, perf_exp());
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = {$urandom, $urandom, $urandom};
    Rst = 1; start = 0; hold = 0; conv_valid = 0;
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    gap(2);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_wr_addr", out_wr_addr, 0);
    frame(64'd0, CM_STD, 0, -1);
    gap(2);
    frame(64'h380, CM_STD, 0, -1);
    gap(1);
    frame(64'd0, 16'h0C00, 0, -1);
    gap(1);
    frame(64'd0, CM_STD, 0, -1);
    gap(1);
    frame(64'd0, CM_STD, 1, -1);
    gap(3);
    frame(64'd0, CM_STD, 0, 7);
    gap(1);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_wr_addr", out_wr_addr, 0);
    frame(64'd0, CM_STD, 0, -1);
    gap(1);
    frame(64'd0, 16'hEE00, 0, -1);
    gap(1);
    repeat (12) begin
      frame({$urandom & $urandom, $urandom & $urandom}, 16'($urandom), 1'($urandom_range(0, 1)), -1);
      gap(1 + $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
